// File: rtl/bist_pattern_misr_if.sv
// Stimulus/response bus between the BIST harness and its controller.
// BIST_GOLDEN_CMP_EN adds the golden-signature input and pass flag.
interface bist_pattern_misr_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] pat_out;
  logic [WIDTH-1:0] resp_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [15:0]      pattern_idx;
`ifdef BIST_GOLDEN_CMP_EN
  logic [WIDTH-1:0] golden;
  logic             pass;

  modport master (
    output start, seed_load, seed_in, resp_in, golden,
    input  pat_out, busy, done, signature, pattern_idx, pass
  );
  modport slave (
    input  start, seed_load, seed_in, resp_in, golden,
    output pat_out, busy, done, signature, pattern_idx, pass
  );
`else
  modport master (
    output start, seed_load, seed_in, resp_in,
    input  pat_out, busy, done, signature, pattern_idx
  );
  modport slave (
    input  start, seed_load, seed_in, resp_in,
    output pat_out, busy, done, signature, pattern_idx
  );
`endif
endinterface

// File: rtl/bist_pattern_misr.sv
// LFSR pattern source plus MISR response compactor for a combinational CUT.
// Optional golden-signature comparator under BIST_GOLDEN_CMP_EN.
module bist_pattern_misr #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      NUM_PATTERNS = 256,
  parameter logic [WIDTH-1:0] LFSR_SEED    = 32'h0000_0001,
  parameter logic [WIDTH-1:0] POLY         = 32'h0040_0007
) (
  input logic                clk,
  input logic                rst_n,
  bist_pattern_misr_if.slave bus
);

  localparam logic [15:0] LastIdx = 16'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [15:0]      idx_q, idx_d;
  logic [WIDTH-1:0] seed_eff;
  logic             seed_ok;
  logic             last;

  function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
  endfunction

  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
  assign seed_ok  = bus.seed_load && (state_q != StRun);
  assign last     = (idx_q == LastIdx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last)      state_d = StDone;
      StDone:  if (bus.start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

  always_comb begin
    seed_d = seed_q;
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    idx_d  = idx_q;
    if (seed_ok) begin
      seed_d = seed_eff;
      lfsr_d = seed_eff;
    end
    if (state_q == StRun) begin
      misr_d = shift(misr_q) ^ bus.resp_in;
      lfsr_d = shift(lfsr_q);
      idx_d  = idx_q + 16'd1;
    end else if (bus.start) begin
      // A seed loaded on the same edge is the one used for this run.
      lfsr_d = seed_ok ? seed_eff : seed_q;
      misr_d = '0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q <= LFSR_SEED;
      lfsr_q <= LFSR_SEED;
      misr_q <= '0;
      idx_q  <= '0;
    end else begin
      seed_q <= seed_d;
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      idx_q  <= idx_d;
    end
  end

  assign bus.pat_out     = lfsr_q;
  assign bus.signature   = misr_q;
  assign bus.pattern_idx = idx_q;

`ifdef BIST_GOLDEN_CMP_EN
  logic pass_q, pass_d;

  always_comb begin
    pass_d = pass_q;
    if (state_q == StRun) begin
      pass_d = last ? (misr_d == bus.golden) : 1'b0;
    end else if (bus.start) begin
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign bus.pass = pass_q;
`endif

endmodule

// File: tb/tb_bist_pattern_misr.sv
// Scoreboard bench for bist_pattern_misr with NUM_PATTERNS=4: stimulus queues
// per-cycle and end-of-run expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bist_pattern_misr;

  typedef struct packed {
    logic [31:0] pat;
    logic [31:0] sig;
    logic [15:0] idx;
  } run_exp_t;

  typedef struct packed {
    logic [31:0] sig;
    logic [15:0] idx;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resp_tie = 1'b1;
  logic [31:0] resp_val = '0;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  run_exp_t    run_q[$];
  done_exp_t   done_q[$];
  run_exp_t    re;
  done_exp_t   de;
  logic        done_prev = 1'b0;

  bist_pattern_misr_if #(.WIDTH(32)) bus ();

  bist_pattern_misr #(
    .WIDTH(32),
    .NUM_PATTERNS(4),
    .LFSR_SEED(32'h0000_0001),
    .POLY(32'h0040_0007)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  assign bus.resp_in = resp_tie ? bus.pat_out : resp_val;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] p, input logic [31:0] s, input logic [15:0] i);
    run_q.push_back('{pat: p, sig: s, idx: i});
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  // Monitor: every RUN cycle and every rising done is checked against the queues.
  always @(negedge clk) begin
    if (bus.busy === 1'b1) begin
      if (run_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL run_unexpected: got busy with idx %h expected no run", bus.pattern_idx);
      end else begin
        re = run_q.pop_front();
        check("run_pat", bus.pat_out, re.pat);
        check("run_sig", bus.signature, re.sig);
        check("run_idx", 32'(bus.pattern_idx), 32'(re.idx));
`ifdef BIST_GOLDEN_CMP_EN
        check("pass_in_run", 32'(bus.pass), 32'd0);
`endif
      end
    end
    if (bus.done === 1'b1 && done_prev !== 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done sig %h expected no done", bus.signature);
      end else begin
        de = done_q.pop_front();
        check("done_sig", bus.signature, de.sig);
        check("done_idx", 32'(bus.pattern_idx), 32'(de.idx));
      end
    end
    done_prev = bus.done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;
`ifdef BIST_GOLDEN_CMP_EN
    bus.golden    = '0;
`endif
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sig", bus.signature, 32'h0);
    check("rst_pat", bus.pat_out, 32'h1);
    check("rst_idx", 32'(bus.pattern_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    // Responses tied to patterns: 1,2,4,8 cancel to a zero signature.
    resp_tie = 1'b1;
    push_run(32'h1, 32'h0, 16'd0);
    push_run(32'h2, 32'h1, 16'd1);
    push_run(32'h4, 32'h0, 16'd2);
    push_run(32'h8, 32'h4, 16'd3);
    done_q.push_back('{sig: 32'h0, idx: 16'd4});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    check("done_latency", 32'(lat + 1), 32'd5);
    tick();
    tick();
    check("frozen_sig", bus.signature, 32'h0);
    check("frozen_pat", bus.pat_out, 32'h10);
    check("frozen_idx", 32'(bus.pattern_idx), 32'd4);
    check("frozen_done", 32'(bus.done), 32'd1);

    // All-ones response, started straight from DONE.
    resp_tie = 1'b0;
    resp_val = 32'hFFFF_FFFF;
    for (int r = 0; r < 2; r++) begin
      push_run(32'h1, 32'h0000_0000, 16'd0);
      push_run(32'h2, 32'hFFFF_FFFF, 16'd1);
      push_run(32'h4, 32'h0040_0006, 16'd2);
      push_run(32'h8, 32'hFF7F_FFF3, 16'd3);
      done_q.push_back('{sig: 32'h0140_001E, idx: 16'd4});
`ifdef BIST_GOLDEN_CMP_EN
      bus.golden = (r == 0) ? 32'h0140_001E : 32'h0140_001F;
`endif
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_done", 32'(bus.done), 32'd0);
      check("b2b_sig", bus.signature, 32'h0);
      check("b2b_idx", 32'(bus.pattern_idx), 32'd0);
      wait_done(lat);
      check("b2b_done_seen", 32'(bus.done), 32'd1);
`ifdef BIST_GOLDEN_CMP_EN
      check("pass", 32'(bus.pass), (r == 0) ? 32'd1 : 32'd0);
`endif
    end

    // Seed with only the top bit set exercises the feedback tap.
    resp_val = 32'h0;
    bus.seed_load = 1'b1;
    bus.seed_in   = 32'h8000_0000;
    tick();
    bus.seed_load = 1'b0;
    check("seed_pat", bus.pat_out, 32'h8000_0000);
    check("seed_still_done", 32'(bus.done), 32'd1);
    push_run(32'h8000_0000, 32'h0, 16'd0);
    push_run(32'h0040_0007, 32'h0, 16'd1);
    push_run(32'h0080_000E, 32'h0, 16'd2);
    push_run(32'h0100_001C, 32'h0, 16'd3);
    done_q.push_back('{sig: 32'h0, idx: 16'd4});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    check("seed_done_seen", 32'(bus.done), 32'd1);

    bus.seed_load = 1'b1;
    bus.seed_in   = 32'h0;
    tick();
    bus.seed_load = 1'b0;
    check("zero_seed_pat", bus.pat_out, 32'h1);

    // Seed load together with start, then RUN-time start/seed_load, then abort.
    resp_val      = 32'h5;
    bus.seed_in   = 32'h2;
    bus.seed_load = 1'b1;
    bus.start     = 1'b1;
    push_run(32'h2, 32'h0, 16'd0);
    push_run(32'h4, 32'h5, 16'd1);
    push_run(32'h8, 32'hF, 16'd2);
    tick();
    bus.seed_in = 32'hDEAD_BEEF;
    tick();
    bus.seed_load = 1'b0;
    bus.start     = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sig", bus.signature, 32'h0);
    check("abort_pat", bus.pat_out, 32'h1);
    check("abort_idx", 32'(bus.pattern_idx), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("run_q_drained", 32'(run_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
